// File: rtl/fp_round_pack.sv
// Binary32 round-and-pack back end for a 24x24 significand multiplier.
// S1 normalizes (including denormal alignment); S2 rounds to nearest-even and packs.
module fp_round_pack (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [47:0] in_mant,
    input  logic        in_nan,
    input  logic        in_inf,
    input  logic        in_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_flags
);

    // Stage 1 registers
    logic        s1_valid;
    logic        s1_special;
    logic [31:0] s1_spec_data;
    logic        s1_sign;
    logic [9:0]  s1_exp;
    logic [23:0] s1_kept;
    logic        s1_guard;
    logic        s1_sticky;

    logic s1_load;
    logic s2_load;

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    // Stage 1 combinational normalization
    logic [5:0]         lz;
    logic signed [11:0] e_in;
    logic signed [11:0] e_norm;
    logic signed [11:0] sh_full;
    logic [47:0]        m_norm;
    logic [46:0]        m_den;
    logic [4:0]         sh;
    logic               denorm;
    logic               extra;
    logic               lost;
    logic               n_special;
    logic [31:0]        n_spec_data;
    logic [9:0]         n_exp;
    logic [23:0]        n_kept;
    logic               n_guard;
    logic               n_sticky;

    always_comb begin
        lz = '0;
        for (int unsigned i = 0; i < 47; i++) begin
            if (in_mant[i]) lz = 6'(46 - i);
        end
    end

    always_comb begin
        e_in   = {{2{in_exp[9]}}, in_exp};
        m_norm = in_mant;
        e_norm = e_in;
        extra  = 1'b0;
        if (in_mant[47]) begin
            m_norm = in_mant >> 1;
            e_norm = e_in + 12'sd1;
            extra  = in_mant[0];
        end else if (!in_mant[46] && in_mant != '0) begin
            m_norm = in_mant << lz;
            e_norm = e_in - $signed({6'd0, lz});
        end

        // Values at or below the normal range are aligned to the fixed denormal scale.
        denorm  = (e_norm <= 12'sd0);
        sh_full = 12'sd1 - e_norm;
        sh      = 5'd0;
        if (denorm) sh = (sh_full > 12'sd26) ? 5'd26 : sh_full[4:0];
        m_den = m_norm[46:0] >> sh;
        lost  = |(m_norm & ~({48{1'b1}} << sh));

        n_kept   = m_den[46:23];
        n_guard  = m_den[22];
        n_sticky = (|m_den[21:0]) | lost | extra;

        if (denorm)
            n_exp = '0;
        else if (e_norm > 12'sd511)
            n_exp = 10'd511;
        else
            n_exp = e_norm[9:0];

        n_special = in_nan || in_inf || in_zero || (in_mant == '0);
        if (in_nan || (in_inf && in_zero))
            n_spec_data = 32'h7FC0_0000;
        else if (in_inf)
            n_spec_data = {in_sign, 8'hFF, 23'd0};
        else
            n_spec_data = {in_sign, 31'd0};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid     <= 1'b0;
            s1_special   <= 1'b0;
            s1_spec_data <= '0;
            s1_sign      <= 1'b0;
            s1_exp       <= '0;
            s1_kept      <= '0;
            s1_guard     <= 1'b0;
            s1_sticky    <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_special   <= n_special;
                s1_spec_data <= n_spec_data;
                s1_sign      <= in_sign;
                s1_exp       <= n_exp;
                s1_kept      <= n_kept;
                s1_guard     <= n_guard;
                s1_sticky    <= n_sticky;
            end
        end
    end

    // Stage 2 combinational rounding and packing
    logic        inc;
    logic [24:0] sum;
    logic [10:0] e_r;
    logic [22:0] frac;
    logic        inexact;
    logic [31:0] r_data;
    logic [2:0]  r_flags;

    always_comb begin
        inc     = s1_guard && (s1_sticky || s1_kept[0]);
        sum     = {1'b0, s1_kept} + {24'd0, inc};
        inexact = s1_guard || s1_sticky;
        // A denormal that rounds up to the hidden-bit position becomes the smallest normal.
        if (s1_exp == '0) begin
            e_r  = {10'd0, sum[23]};
            frac = sum[22:0];
        end else if (sum[24]) begin
            e_r  = {1'b0, s1_exp} + 11'd1;
            frac = sum[23:1];
        end else begin
            e_r  = {1'b0, s1_exp};
            frac = sum[22:0];
        end

        if (s1_special) begin
            r_data  = s1_spec_data;
            r_flags = 3'b000;
        end else if (e_r >= 11'd255) begin
            r_data  = {s1_sign, 8'hFF, 23'd0};
            r_flags = 3'b101;
        end else begin
            r_data  = {s1_sign, e_r[7:0], frac};
            r_flags = {1'b0, inexact && (e_r == 11'd0), inexact};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_flags <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data  <= r_data;
                out_flags <= r_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_round_pack.sv
// Self-checking bench for fp_round_pack: directed vectors, randomized traffic against
// an exact-value rounding model, backpressure and asynchronous reset scenarios.
module tb_fp_round_pack;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_mant;
    logic        in_nan;
    logic        in_inf;
    logic        in_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_flags;

    int n_checks = 0;
    int n_fail   = 0;

    fp_round_pack dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_nan    (in_nan),
        .in_inf    (in_inf),
        .in_zero   (in_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Exact value is m * 2^(e-173); scale to the target significand grid and round half-even.
    function automatic logic [34:0] ref_model(input logic s, input int e, input logic [47:0] m,
                                              input logic nan, input logic inf, input logic zero);
        logic [63:0] mm;
        logic [63:0] sig;
        logic        g;
        logic        st;
        logic [2:0]  fl;
        int p, be, k, r, field;
        if (nan || (inf && zero)) return {3'b000, 32'h7FC0_0000};
        if (inf) return {3'b000, s, 8'hFF, 23'd0};
        if (zero || m == 48'd0) return {3'b000, s, 31'd0};
        mm = {16'd0, m};
        p = 0;
        for (int i = 0; i < 48; i++) if (m[i]) p = i;
        be = e + p - 46;
        k  = (be >= 1) ? (23 - p) : (e - 24);
        r  = -k;
        g  = 1'b0;
        st = 1'b0;
        if (r <= 0) begin
            sig = mm << (-r);
        end else if (r > 48) begin
            sig = 64'd0;
            st  = 1'b1;
        end else begin
            sig = mm >> r;
            g   = mm[r-1];
            st  = (mm & ((64'd1 << (r - 1)) - 64'd1)) != 64'd0;
        end
        if (g && (st || sig[0])) sig = sig + 64'd1;
        if (be >= 1) begin
            if (sig == (64'd1 << 24)) begin
                sig = sig >> 1;
                be  = be + 1;
            end
            field = be;
        end else begin
            field = (sig >= (64'd1 << 23)) ? 1 : 0;
        end
        if (field >= 255) return {3'b101, s, 8'hFF, 23'd0};
        fl = {1'b0, (g || st) && (field == 0), g || st};
        return {fl, s, field[7:0], sig[22:0]};
    endfunction

    task automatic drive(input logic s, input logic [9:0] e, input logic [47:0] m,
                         input logic n, input logic i, input logic z);
        in_sign = s;
        in_exp  = e;
        in_mant = m;
        in_nan  = n;
        in_inf  = i;
        in_zero = z;
    endtask

    task automatic gen_random();
        logic [63:0] t;
        int roll;
        t    = {$urandom, $urandom};
        roll = $urandom_range(0, 19);
        in_sign = 1'($urandom_range(0, 1));
        in_exp  = 10'(int'($urandom_range(0, 600)) - 200);
        in_mant = t[47:0] >> $urandom_range(0, 47);
        in_nan  = (roll == 0);
        in_inf  = (roll == 1) || (roll == 3);
        in_zero = (roll == 2) || (roll == 3);
        if (roll == 4) begin
            in_mant[46]   = 1'b1;
            in_mant[22]   = 1'b1;
            in_mant[21:0] = '0;
        end
    endtask

    function automatic logic [34:0] ref_of_inputs();
        return ref_model(in_sign, int'($signed(in_exp)), in_mant, in_nan, in_inf, in_zero);
    endfunction

    // Sends one product into an empty pipeline with out_ready=1 and waits for its result.
    task automatic run_one(output logic [31:0] d, output logic [2:0] f, output int lat, output bit to);
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        to = !out_valid;
        d  = out_data;
        f  = out_flags;
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 10'd0, 48'd0, 1'b0, 1'b0, 1'b0);
        #23;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++;
        if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 00000000", out_data); end
        n_checks++;
        if (out_flags !== 3'b000) begin n_fail++; $display("FAIL reset_out_flags: got %b want 000", out_flags); end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    logic [9:0]  dv_exp  [10] = '{10'd127, 10'd127, 10'd127, 10'd127, 10'd255, 10'h3E2, 10'd0, 10'd127, 10'd127, 10'd127};
    logic [47:0] dv_mant [10] = '{48'h4000_0000_0000, 48'h8000_0000_0000, 48'h4000_0040_0000, 48'h4000_00C0_0000,
                                  48'h4000_0000_0000, 48'h4000_0000_0000, 48'h4000_0000_0000, 48'h4000_0000_0000,
                                  48'h4000_0000_0000, 48'h0};
    logic        dv_sign [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic        dv_nan  [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic        dv_inf  [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    logic        dv_zero [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    logic [31:0] dv_data [10] = '{32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0002, 32'h7F80_0000,
                                  32'h0000_0000, 32'h0040_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'h7FC0_0000};
    logic [2:0]  dv_flag [10] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b101, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000};

    task automatic test_directed();
        logic [31:0] d;
        logic [2:0]  f;
        int lat;
        bit to;
        for (int i = 0; i < 10; i++) begin
            drive(dv_sign[i], dv_exp[i], dv_mant[i], dv_nan[i], dv_inf[i], dv_zero[i]);
            run_one(d, f, lat, to);
            n_checks++;
            if (to || lat != 2) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d cycles (timeout=%0b) want 2", i, lat, to);
            end
            n_checks++;
            if (d !== dv_data[i]) begin n_fail++; $display("FAIL directed_data[%0d]: got %h want %h", i, d, dv_data[i]); end
            n_checks++;
            if (f !== dv_flag[i]) begin n_fail++; $display("FAIL directed_flags[%0d]: got %b want %b", i, f, dv_flag[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [2:0]  f;
        logic [34:0] exp_v;
        int lat;
        bit to;
        for (int i = 0; i < 150; i++) begin
            gen_random();
            exp_v = ref_of_inputs();
            run_one(d, f, lat, to);
            n_checks++;
            if (to || {f, d} !== exp_v) begin
                n_fail++;
                $display("FAIL random[%0d]: s=%b e=%h m=%h nan/inf/zero=%b%b%b got %b_%h want %b_%h (timeout=%0b)",
                         i, in_sign, in_exp, in_mant, in_nan, in_inf, in_zero, f, d, exp_v[34:32], exp_v[31:0], to);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [34:0] q[$];
        logic [34:0] exp_v;
        logic [31:0] held_d;
        logic [2:0]  held_f;
        bit stalled;
        bit in_fire;
        bit out_fire;
        int drain;
        stalled = 1'b0;
        held_d  = '0;
        held_f  = '0;
        for (int c = 0; c < 340; c++) begin
            @(negedge clk);
            if (stalled) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== held_d || out_flags !== held_f) begin
                    n_fail++;
                    $display("FAIL stall_hold[%0d]: got v=%b %b_%h want v=1 %b_%h", c, out_valid, out_flags, out_data, held_f, held_d);
                end
            end
            gen_random();
            in_valid  = (c < 300) && ($urandom_range(0, 3) != 0);
            out_ready = (c >= 300) || ($urandom_range(0, 2) != 0);
            #1;
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra[%0d]: got %b_%h want no output", c, out_flags, out_data);
                end else begin
                    exp_v = q.pop_front();
                    if ({out_flags, out_data} !== exp_v) begin
                        n_fail++;
                        $display("FAIL stream_data[%0d]: got %b_%h want %b_%h", c, out_flags, out_data, exp_v[34:32], exp_v[31:0]);
                    end
                end
            end
            if (in_fire) q.push_back(ref_of_inputs());
            stalled = out_valid && !out_ready;
            held_d  = out_data;
            held_f  = out_flags;
            @(posedge clk);
        end
        drain = q.size();
        n_checks++;
        if (drain != 0) begin n_fail++; $display("FAIL stream_drain: got %0d results outstanding want 0", drain); end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int idx;
        int k;
        int unstable;
        bit have;
        bit fire;
        logic [31:0] held;
        idx      = 0;
        k        = 0;
        unstable = 0;
        have     = 1'b0;
        held     = '0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            in_valid = (idx < 4);
            if (idx < 4) drive(dv_sign[idx], dv_exp[idx], dv_mant[idx], 1'b0, 1'b0, 1'b0);
            #1;
            if (out_valid) begin
                if (!have) begin held = out_data; have = 1'b1; end
                else if (out_data !== held) unstable++;
            end
            fire = in_valid && in_ready;
            @(posedge clk);
            if (fire) idx++;
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (idx != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d want 2", idx); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        n_checks++;
        if (!have || unstable != 0 || out_data !== held) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d changes (seen=%0b) want 0", unstable, have);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && k < 4; c++) begin
            if (c > 0) @(negedge clk);
            in_valid = (idx < 4);
            if (idx < 4) drive(dv_sign[idx], dv_exp[idx], dv_mant[idx], 1'b0, 1'b0, 1'b0);
            #1;
            if (out_valid) begin
                n_checks++;
                if (out_data !== dv_data[k] || out_flags !== dv_flag[k]) begin
                    n_fail++;
                    $display("FAIL bp_order[%0d]: got %b_%h want %b_%h", k, out_flags, out_data, dv_flag[k], dv_data[k]);
                end
                k++;
            end
            fire = in_valid && in_ready;
            @(posedge clk);
            if (fire) idx++;
        end
        n_checks++;
        if (k != 4) begin n_fail++; $display("FAIL bp_count: got %0d results want 4", k); end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        int idx;
        int stale;
        bit fire;
        idx   = 0;
        stale = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 6 && idx < 2; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            drive(1'b0, 10'd127, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0);
            #1;
            fire = in_ready;
            @(posedge clk);
            if (fire) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || idx != 2) begin
            n_fail++;
            $display("FAIL midreset_fill: got out_valid=%b accepted=%0d want 1 and 2", out_valid, idx);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_async: got out_valid=%b want 0", out_valid); end
        n_checks++;
        if (out_data !== 32'h0 || out_flags !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_data: got %b_%h want 000_00000000", out_flags, out_data);
        end
        @(negedge clk);
        resetn    = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        n_checks++;
        if (stale != 0) begin n_fail++; $display("FAIL midreset_stale: got %0d stale outputs want 0", stale); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_round_pack.md
FP_ROUND_PACK -- requirements
Module: fp_round_pack

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port in_valid  input  1  upstream multiplier product valid.
REQ-004 SHALL have port in_ready  output  1  block accepts a product this cycle.
REQ-005 SHALL have port in_sign  input  1  product sign (s1 ^ s2).
REQ-006 SHALL have port in_exp  input  10  two's-complement biased exponent sum e1+e2-127.
REQ-007 SHALL have port in_mant  input  48  raw 24x24 significand product; binary point between bits 46 and 45.
REQ-008 SHALL have port in_nan, in_inf, in_zero  input  1 each  special-case flags from upstream decode.
REQ-009 SHALL have port out_valid  output  1  packed result valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port out_data  output  32  IEEE-754 binary32 result.
REQ-012 SHALL have port out_flags  output  3  {overflow, underflow, inexact}.

Function
REQ-013 SHALL be a 2-stage pipeline: S1 normalizes, S2 rounds and packs; latency is 2 cycles from accepted input to out_valid when out_ready stays 1.
REQ-014 SHALL transfer on valid&&ready at both ports; S2 loads when !S2.valid || out_ready; S1 loads when !S1.valid || S2 loads; in_ready = S1 load condition (combinational).
REQ-015 SHALL hold out_data/out_flags stable while out_valid=1 and out_ready=0; no drop, no duplication, order preserved.
REQ-016 S1 SHALL, if in_mant[47]=1, shift right 1 and set exp+1 (shifted-out bit feeds sticky); else, if in_mant[46]=0 and in_mant!=0, shift left by leading-zero count of bits [46:0] and subtract it from exp.
REQ-017 S1 SHALL, if normalized exp <= 0, shift right by (1-exp), saturating at 26, ORing all shifted-out bits into sticky, and mark result denormal (exponent field 0).
REQ-018 S1 SHALL carry kept significand [46:23] (24 bits), guard = bit 22, sticky = OR of bits [21:0] plus any shifted-out bits, with a 10-bit signed exponent.
REQ-019 S2 SHALL round to nearest, ties to even: increment when guard && (sticky || kept LSB).
REQ-020 S2 SHALL, on rounding carry out of 24 bits, shift right 1 and set exp+1; a denormal rounding to 0x800000 SHALL become exponent field 1.
REQ-021 S2 SHALL produce +/-infinity (exp 0xFF, mant 0) with overflow=1 and inexact=1 when final exp >= 255.
REQ-022 inexact SHALL be guard || sticky; underflow SHALL be inexact && final exponent field == 0 (tininess after rounding).
REQ-023 Special priority SHALL be nan > inf > zero > numeric: nan -> 0x7FC00000; inf -> {sign,0xFF,0}; zero or in_mant==0 -> {sign,0,0}; all flags 0 for specials.
REQ-024 in_inf && in_zero together SHALL yield 0x7FC00000 (invalid product).

Reset
REQ-025 resetn low SHALL asynchronously clear S1/S2 valid, out_valid=0, out_data=0x00000000, out_flags=0; in-flight products are discarded.
REQ-026 in_ready SHALL be 1 from the first edge after resetn deasserts (pipeline empty).

Verification
REQ-027 1.0x1.0: exp=127, mant=0x400000000000 -> out_data=0x3F800000, flags=000, out_valid exactly 2 cycles after accept.
REQ-028 Carry normalize: exp=127, mant=0x800000000000 -> 0x40000000; tie-even down: mant=0x400000400000 -> 0x3F800000, inexact=1; tie-even up: mant=0x400000C00000 -> 0x3F800002, inexact=1.
REQ-029 Overflow: exp=255, mant=0x400000000000 -> 0x7F800000, flags=101; underflow: exp=-30, mant=0x400000000000 -> 0x00000000, flags=011; exp=0, mant=0x400000000000 -> 0x00400000, flags=000.
REQ-030 Specials: in_nan=1 -> 0x7FC00000; in_inf=1, sign=1 -> 0xFF800000; in_inf && in_zero -> 0x7FC00000; all with flags=000.
REQ-031 Backpressure: offer 4 back-to-back inputs with out_ready=0 -> in_ready drops after 2 accepted; raise out_ready -> all 4 results emerge in order, out_data stable while stalled.
REQ-032 Reset mid-stream: assert resetn low with both stages valid -> out_valid=0 immediately (asynchronously); after release no stale result appears.
